// File: rtl/fp32_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-add mantissa product
// (one bit per clock), then normalise and pack, behind a start/busy/done handshake.
module fp32_multiplier_seq #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        over_under
);

  localparam int PW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(MANT_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_PACK} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [PW-1:0]      ma_q, ma_d;
  logic [MANT_W-1:0]  mb_q, mb_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [9:0]  e_q, e_d;
  logic               zero_q, zero_d;
  logic               special_q, special_d;
  logic [31:0]        product_q, product_d;
  logic               ou_q, ou_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    zero_d    = zero_q;
    special_d = special_q;
    product_d = product_q;
    ou_d      = ou_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        // Denormals carry a zero hidden bit and an effective exponent of 1.
        sign_d    = a_q[31] ^ b_q[31];
        ea_d      = (a_q[30:23] == 8'h00) ? 8'd1 : a_q[30:23];
        eb_d      = (b_q[30:23] == 8'h00) ? 8'd1 : b_q[30:23];
        ma_d      = PW'({a_q[30:23] != 8'h00, a_q[22:0]});
        mb_d      = MANT_W'({b_q[30:23] != 8'h00, b_q[22:0]});
        zero_d    = (a_q[30:0] == 31'h0) || (b_q[30:0] == 31'h0);
        special_d = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = S_MUL;
      end

      S_MUL: begin
        // ma_q is pre-shifted each cycle, so it always equals mant_a << cnt.
        if (mb_q[0]) begin
          acc_d = acc_q + ma_q;
        end
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          e_d     = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'(BIAS);
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (special_q || zero_q) begin
          state_d = S_PACK;
        end else if (acc_q[PW-1]) begin
          acc_d   = acc_q >> 1;
          e_d     = e_q + 10'sd1;
          state_d = S_PACK;
        end else if (!acc_q[PW-2] && (e_q > 10'sd1)) begin
          acc_d = acc_q << 1;
          e_d   = e_q - 10'sd1;
        end else begin
          state_d = S_PACK;
        end
      end

      S_PACK: begin
        // Truncating rounding: everything below the 23 kept fraction bits is dropped.
        if (special_q) begin
          product_d = {sign_q, 8'hFF, 23'h0};
          ou_d      = 1'b1;
        end else if (zero_q) begin
          product_d = {sign_q, 31'h0};
          ou_d      = 1'b0;
        end else if (e_q > 10'sd254) begin
          product_d = {sign_q, 8'hFF, 23'h0};
          ou_d      = 1'b1;
        end else if (e_q < 10'sd1) begin
          product_d = {sign_q, 31'h0};
          ou_d      = 1'b1;
        end else if (!acc_q[PW-2]) begin
          product_d = {sign_q, 8'h00, acc_q[PW-3 -: 23]};
          ou_d      = 1'b0;
        end else begin
          product_d = {sign_q, e_q[7:0], acc_q[PW-3 -: 23]};
          ou_d      = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      e_q       <= '0;
      zero_q    <= 1'b0;
      special_q <= 1'b0;
      product_q <= '0;
      ou_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      zero_q    <= zero_d;
      special_q <= special_d;
      product_q <= product_d;
      ou_q      <= ou_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product    = product_q;
  assign over_under = ou_q;

endmodule

// File: tb/tb_fp32_multiplier_seq.sv
// Directed and randomised checks of fp32_multiplier_seq using an expected-result queue.
module tb_fp32_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        over_under;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  fp32_multiplier_seq #(.MANT_W(24), .BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .over_under(over_under)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {over_under, product} computed with a native multiply.
  function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic [7:0] ex, ey;
    logic [47:0] p;
    int e;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    p  = 48'({ex != 8'h00, x[22:0]}) * 48'({ey != 8'h00, y[22:0]});
    e  = ((ex == 8'h00) ? 1 : int'(ex)) + ((ey == 8'h00) ? 1 : int'(ey)) - 127;
    if (ex == 8'hFF || ey == 8'hFF) return {1'b1, s, 8'hFF, 23'h0};
    if (x[30:0] == 31'h0 || y[30:0] == 31'h0) return {1'b0, s, 31'h0};
    if (p[47]) begin
      p = p >> 1;
      e++;
    end else begin
      while (!p[46] && e > 1) begin
        p = p << 1;
        e--;
      end
    end
    if (e > 254) return {1'b1, s, 8'hFF, 23'h0};
    if (e < 1) return {1'b1, s, 31'h0};
    if (!p[46]) return {1'b0, s, 8'h00, p[45:23]};
    return {1'b0, s, e[7:0], p[45:23]};
  endfunction

  // k0 = index of the first falling edge still to wait for (edge 1 follows the accept edge).
  task automatic wait_done(input string tag, input int k0, input int exp_lat);
    int lat;
    logic [32:0] r;
    lat = 0;
    for (int k = k0; k <= k0 + 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check({tag, "_product"}, product, r[31:0]);
        check({tag, "_over_under"}, 32'(over_under), 32'(r[32]));
        $display("[TB] %s: product=%h over_under=%0b latency=%0d", tag, product, over_under, lat);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [32:0] expv, input int exp_lat);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, 2, exp_lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'h0);
    check("rst_over_under", 32'(over_under), 32'd0);
    rst_n = 1'b1;

    // Directed operands
    run_op("mul_2x3",      32'h40000000, 32'h40400000, {1'b0, 32'h40C00000}, 28);
    run_op("mul_1p5sq",    32'h3FC00000, 32'h3FC00000, {1'b0, 32'h40100000}, 28);
    run_op("mul_neg_zero", 32'hBF800000, 32'h00000000, {1'b0, 32'h80000000}, 28);
    run_op("mul_overflow", 32'h7F000000, 32'h7F000000, {1'b1, 32'h7F800000}, 28);
    run_op("mul_underflow",32'h00800000, 32'h00800000, {1'b1, 32'h00000000}, 28);
    run_op("mul_inf",      32'h7F800000, 32'h3F800000, {1'b1, 32'h7F800000}, 28);
    run_op("mul_denorm_out",32'h00400000, 32'h3F800000, {1'b0, 32'h00400000}, 28);
    run_op("mul_denorm_in",32'h00400000, 32'h4B000000, {1'b0, 32'h0B800000}, 29);

    // Random normal operands
    for (int i = 0; i < 6; i++) begin
      ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      run_op($sformatf("mul_rand%0d", i), ra, rb, ref_mul(ra, rb), 28);
    end

    // Start while busy is ignored
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    exp_q.push_back({1'b0, 32'h40C00000});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'h3FC00000; b = 32'h3FC00000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 7, 28);

    // Start held through done: second op accepted with no bubble
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; start = 1'b1;
    exp_q.push_back({1'b0, 32'h40800000});
    @(negedge clk);
    a = 32'hC0400000; b = 32'h40400000;
    exp_q.push_back({1'b0, 32'hC1100000});
    wait_done("b2b_first", 2, 28);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", 2, 28);

    // Reset mid-operation aborts without a done
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    exp_q.push_back({1'b0, 32'h40C00000});
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", product, 32'h0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op("after_rst", 32'h3FC00000, 32'h40000000, {1'b0, 32'h40400000}, 28);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
